// File: rtl/tcb_lite_peri_gpio_irq_if.sv
// TCB-Lite register access interface shared by the lite peripherals.
// The manager drives the request; the subordinate answers with rdy, rdt and err.
interface tcb_lite_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic            vld;
  logic            rdy;
  logic            wen;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] ben;
  logic [DW-1:0]   wdt;
  logic [DW-1:0]   rdt;
  logic            err;

  modport master (
    output vld, wen, adr, ben, wdt,
    input  rdy, rdt, err
  );

  modport slave (
    input  vld, wen, adr, ben, wdt,
    output rdy, rdt, err
  );

endinterface

// File: rtl/tcb_lite_peri_gpio_irq.sv
// TCB-Lite GPIO peripheral with per-pin rising/falling edge interrupts,
// atomic SET/CLR aliases for the output register, W1C interrupt status
// and a configurable input synchroniser. Unmapped offsets answer with err.
module tcb_lite_peri_gpio_irq #(
  parameter int unsigned GDW = 32,
  parameter int unsigned CDC = 2,
  parameter bit          IRQ = 1'b1,
  parameter int unsigned DLY = 0,
  parameter bit          HLD = 1'b0
)(
  input  logic           clk,
  input  logic           rst,
  output logic [GDW-1:0] gpio_o,
  output logic [GDW-1:0] gpio_e,
  input  logic [GDW-1:0] gpio_i,
  tcb_lite_if.slave      sub,
  output logic           irq
);

  localparam int unsigned DW = 32;

  localparam logic [3:0] REG_OEN = 4'h0;
  localparam logic [3:0] REG_OUT = 4'h1;
  localparam logic [3:0] REG_IEN = 4'h2;
  localparam logic [3:0] REG_IN  = 4'h3;
  localparam logic [3:0] REG_IRE = 4'h4;
  localparam logic [3:0] REG_IFE = 4'h5;
  localparam logic [3:0] REG_ISR = 4'h6;
  localparam logic [3:0] REG_SET = 4'h8;
  localparam logic [3:0] REG_CLR = 4'h9;

  // Only the two handshake flavours below are implemented; anything else
  // must be caught when the design is elaborated.
  if ((DLY != 0) && (DLY != 1)) begin : g_bad_dly
    $error("tcb_lite_peri_gpio_irq: response delay DLY must be 0 or 1");
  end
  if (HLD) begin : g_bad_hld
    $error("tcb_lite_peri_gpio_irq: HLD=1 handshake is not supported");
  end
  if ((GDW < 1) || (GDW > DW)) begin : g_bad_gdw
    $error("tcb_lite_peri_gpio_irq: GDW must be within 1..32");
  end
  if (CDC > 4) begin : g_bad_cdc
    $error("tcb_lite_peri_gpio_irq: CDC must be within 0..4");
  end

  logic [GDW-1:0] oen;
  logic [GDW-1:0] out;
  logic [GDW-1:0] ien;
  logic [GDW-1:0] ire;
  logic [GDW-1:0] ife;
  logic [GDW-1:0] isr;
  logic [GDW-1:0] syn;
  logic [GDW-1:0] cur;
  logic [GDW-1:0] prv;

  logic [3:0]     reg_sel;
  logic           adr_err;
  logic           xfer;
  logic           wr;
  logic [GDW-1:0] wmask;
  logic [GDW-1:0] wbits;
  logic [DW-1:0]  rd_data;
  logic           unused_wdt;

  // The subordinate never stalls, so every valid cycle is a transfer.
  assign sub.rdy = 1'b1;
  assign xfer    = sub.vld & sub.rdy;

  // Offsets past CLR and the hole at 0x1C are rejected; a rejected access
  // never changes state and always reads back as zero.
  assign reg_sel = sub.adr[5:2];
  assign adr_err = (sub.adr >= 32'h28) || (reg_sel == 4'h7);
  assign wr      = xfer & sub.wen & ~adr_err;

  // Expand the byte enables to a per-bit mask over the GPIO width; a
  // disabled lane behaves like a zero data byte for SET/CLR/W1C.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < int'(GDW); i++) begin
      wmask[i] = sub.ben[i/8];
    end
  end

  assign wbits      = sub.wdt[GDW-1:0] & wmask;
  assign unused_wdt = ^sub.wdt;

  // Control registers; SET and CLR are aliases that modify OUT in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      oen <= '0;
      out <= '0;
      ien <= '0;
    end else if (wr) begin
      case (reg_sel)
        REG_OEN: oen <= (oen & ~wmask) | wbits;
        REG_OUT: out <= (out & ~wmask) | wbits;
        REG_IEN: ien <= (ien & ~wmask) | wbits;
        REG_SET: out <= out | wbits;
        REG_CLR: out <= out & ~wbits;
        default: ;
      endcase
    end
  end

  assign gpio_o = out;
  assign gpio_e = oen;

  // Pad inputs are asynchronous; pass them through CDC flops unless the
  // integrator has chosen to use them directly.
  if (CDC == 0) begin : g_no_cdc
    assign syn = gpio_i;
  end else begin : g_cdc
    logic [GDW-1:0] chain [CDC];

    // Shift chain clearing to zero on reset so no stale edge survives it.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(CDC); i++) begin
          chain[i] <= '0;
        end
      end else begin
        chain[0] <= gpio_i;
        for (int i = 1; i < int'(CDC); i++) begin
          chain[i] <= chain[i-1];
        end
      end
    end

    assign syn = chain[CDC-1];
  end

  // Masking happens before edge detection, so toggling IEN on a high pin
  // is itself seen as a rising or falling edge.
  assign cur = syn & ien;

  // Edge history: the masked input value seen on the previous clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      prv <= '0;
    end else begin
      prv <= cur;
    end
  end

  if (IRQ) begin : g_irq
    logic [GDW-1:0] w1c;
    logic [GDW-1:0] rise;
    logic [GDW-1:0] fall;

    assign w1c  = (wr && (reg_sel == REG_ISR)) ? wbits : '0;
    assign rise = cur & ~prv & ire;
    assign fall = ~cur & prv & ife;

    // Edge enables plus status; a new event outranks a W1C on the same bit
    // so an edge arriving while software clears is never lost.
    always_ff @(posedge clk) begin
      if (rst) begin
        ire <= '0;
        ife <= '0;
        isr <= '0;
      end else begin
        if (wr && (reg_sel == REG_IRE)) begin
          ire <= (ire & ~wmask) | wbits;
        end
        if (wr && (reg_sel == REG_IFE)) begin
          ife <= (ife & ~wmask) | wbits;
        end
        isr <= (isr & ~w1c) | rise | fall;
      end
    end

    assign irq = |isr;
  end else begin : g_no_irq
    assign ire = '0;
    assign ife = '0;
    assign isr = '0;
    assign irq = 1'b0;
  end

  // Read multiplexer over the register map, zero-extended to the bus width.
  always_comb begin
    rd_data = '0;
    if (!adr_err) begin
      case (reg_sel)
        REG_OEN: rd_data[GDW-1:0] = oen;
        REG_OUT: rd_data[GDW-1:0] = out;
        REG_IEN: rd_data[GDW-1:0] = ien;
        REG_IN:  rd_data[GDW-1:0] = cur;
        REG_IRE: rd_data[GDW-1:0] = ire;
        REG_IFE: rd_data[GDW-1:0] = ife;
        REG_ISR: rd_data[GDW-1:0] = isr;
        default: rd_data = '0;
      endcase
    end
  end

  if (DLY == 0) begin : g_rsp_comb
    assign sub.rdt = rd_data;
    assign sub.err = xfer & adr_err;
  end else begin : g_rsp_reg
    logic [DW-1:0] rdt_q;
    logic          err_q;

    // Registered response: captured on the transfer edge, err only pulses
    // for the cycle that follows the offending transfer.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdt_q <= '0;
        err_q <= 1'b0;
      end else if (xfer) begin
        rdt_q <= rd_data;
        err_q <= adr_err;
      end else begin
        err_q <= 1'b0;
      end
    end

    assign sub.rdt = rdt_q;
    assign sub.err = err_q;
  end

endmodule

// File: tb/tb_tcb_lite_peri_gpio_irq.sv
// Bench for the TCB-Lite GPIO peripheral. Two instances run side by side,
// one with a combinational response and one with a registered response,
// both compared against a register-map level reference model.
module tb_tcb_lite_peri_gpio_irq;

  localparam int CDC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_i;
  logic [31:0] gpio_o0, gpio_e0, gpio_o1, gpio_e1;
  logic        irq0, irq1;

  int n_checks = 0;
  int n_fail   = 0;

  tcb_lite_if bus0 ();
  tcb_lite_if bus1 ();

  tcb_lite_peri_gpio_irq #(
    .GDW(32), .CDC(CDC), .IRQ(1'b1), .DLY(0), .HLD(1'b0)
  ) dut0 (
    .clk    (clk),
    .rst    (rst),
    .gpio_o (gpio_o0),
    .gpio_e (gpio_e0),
    .gpio_i (gpio_i),
    .sub    (bus0),
    .irq    (irq0)
  );

  tcb_lite_peri_gpio_irq #(
    .GDW(32), .CDC(CDC), .IRQ(1'b1), .DLY(1), .HLD(1'b0)
  ) dut1 (
    .clk    (clk),
    .rst    (rst),
    .gpio_o (gpio_o1),
    .gpio_e (gpio_e1),
    .gpio_i (gpio_i),
    .sub    (bus1),
    .irq    (irq1)
  );

  always #5 clk = ~clk;

  // Reference model state: registers as software sees them, plus the list
  // of pad values still travelling through the synchroniser.
  bit [31:0] m_oen, m_out, m_ien, m_ire, m_ife, m_isr, m_prv;
  bit [31:0] pad_q[$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_oen = 0; m_out = 0; m_ien = 0; m_ire = 0; m_ife = 0; m_isr = 0; m_prv = 0;
    pad_q.delete();
    for (int i = 0; i < CDC; i++) pad_q.push_back(32'h0);
  endtask

  function automatic bit model_err(input logic [31:0] a);
    return (a >= 32'h28) || (a == 32'h1C);
  endfunction

  function automatic bit [31:0] model_read(input logic [31:0] a);
    if (model_err(a)) return 32'h0;
    case (a)
      32'h00:  return m_oen;
      32'h04:  return m_out;
      32'h08:  return m_ien;
      32'h0C:  return pad_q[0] & m_ien;
      32'h10:  return m_ire;
      32'h14:  return m_ife;
      32'h18:  return m_isr;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Advance the model by one clock edge given the request and pad value
  // presented during the cycle before that edge.
  task automatic model_edge(input bit rs, input bit do_x, input bit we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd, input logic [31:0] pad);
    bit [31:0] cur, ev, m, d, w1c;
    if (rs) begin
      model_reset();
      return;
    end
    cur = pad_q[0] & m_ien;
    ev  = (cur & ~m_prv & m_ire) | (~cur & m_prv & m_ife);
    w1c = 0;
    if (do_x && we && !model_err(a)) begin
      m = lanes(be);
      d = wd & m;
      case (a)
        32'h00: m_oen = (m_oen & ~m) | d;
        32'h04: m_out = (m_out & ~m) | d;
        32'h08: m_ien = (m_ien & ~m) | d;
        32'h10: m_ire = (m_ire & ~m) | d;
        32'h14: m_ife = (m_ife & ~m) | d;
        32'h18: w1c   = d;
        32'h20: m_out = m_out | d;
        32'h24: m_out = m_out & ~d;
        default: ;
      endcase
    end
    m_isr = (m_isr & ~w1c) | ev;
    m_prv = cur;
    void'(pad_q.pop_front());
    pad_q.push_back(pad);
  endtask

  // One bus cycle on both instances, entered and left 1 time unit after a
  // rising edge; pins are checked mid-cycle, responses where each is valid.
  task automatic apply_stimulus(input bit do_x, input bit we, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    bit [31:0] exp_rd;
    bit        exp_err;
    bus0.vld = do_x; bus0.wen = we; bus0.adr = a; bus0.ben = be; bus0.wdt = wd;
    bus1.vld = do_x; bus1.wen = we; bus1.adr = a; bus1.ben = be; bus1.wdt = wd;
    exp_rd  = model_read(a);
    exp_err = model_err(a);
    @(negedge clk);
    check_output("gpio_o0", gpio_o0, m_out);
    check_output("gpio_e0", gpio_e0, m_oen);
    check_output("irq0", {31'b0, irq0}, {31'b0, |m_isr});
    check_output("gpio_o1", gpio_o1, m_out);
    check_output("gpio_e1", gpio_e1, m_oen);
    check_output("irq1", {31'b0, irq1}, {31'b0, |m_isr});
    if (do_x) begin
      check_output("rdy0", {31'b0, bus0.rdy}, 32'h1);
      check_output("err0", {31'b0, bus0.err}, {31'b0, exp_err});
      if (!we) check_output("rdt0", bus0.rdt, exp_rd);
    end
    rd = bus0.rdt;
    er = bus0.err;
    @(posedge clk);
    model_edge(rst, do_x, we, a, be, wd, gpio_i);
    #1;
    if (do_x && rst) begin
      check_output("err1_rst", {31'b0, bus1.err}, 32'h0);
    end else if (do_x) begin
      check_output("err1", {31'b0, bus1.err}, {31'b0, exp_err});
      if (!we) check_output("rdt1", bus1.rdt, exp_rd);
    end
    bus0.vld = 1'b0;
    bus1.vld = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [31:0] rd;
    logic        er;
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, rd, er);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] rd;
    logic        er;
    apply_stimulus(1'b1, 1'b1, a, be, d, rd, er);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] rd, output logic er);
    apply_stimulus(1'b1, 1'b0, a, 4'hF, 32'h0, rd, er);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;

    rst    = 1'b1;
    gpio_i = 32'h0;
    bus0.vld = 1'b0; bus0.wen = 1'b0; bus0.adr = '0; bus0.ben = '0; bus0.wdt = '0;
    bus1.vld = 1'b0; bus1.wen = 1'b0; bus1.adr = '0; bus1.ben = '0; bus1.wdt = '0;

    $display("[TB] reset");
    @(posedge clk);
    model_reset();
    #1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_reg(32'(i * 4), rd, er);
      check_output("reset_read", rd, 32'h0);
    end

    $display("[TB] output data, enable, SET and CLR");
    wr_reg(32'h04, 4'hF, 32'h01234567);
    wr_reg(32'h00, 4'hF, 32'h76543210);
    wr_reg(32'h20, 4'hF, 32'h80000000);
    wr_reg(32'h24, 4'hF, 32'h00000007);
    check_output("setclr_gpio_o", gpio_o0, 32'h81234560);
    check_output("setclr_gpio_e", gpio_e0, 32'h76543210);
    rd_reg(32'h20, rd, er);
    check_output("set_reads_zero", rd, 32'h0);

    $display("[TB] input path");
    wr_reg(32'h08, 4'hF, 32'hFFFFFFFF);
    gpio_i = 32'h89ABCDEF;
    idle(CDC + 1);
    rd_reg(32'h0C, rd, er);
    check_output("in_full", rd, 32'h89ABCDEF);
    wr_reg(32'h08, 4'hF, 32'h0000FFFF);
    rd_reg(32'h0C, rd, er);
    check_output("in_masked", rd, 32'h0000CDEF);

    $display("[TB] edge interrupts");
    gpio_i = 32'h0;
    idle(CDC + 1);
    wr_reg(32'h10, 4'hF, 32'h1);
    wr_reg(32'h14, 4'hF, 32'h2);
    gpio_i = 32'h3;
    idle(CDC + 1);
    check_output("rise_irq", {31'b0, irq0}, 32'h1);
    rd_reg(32'h18, rd, er);
    check_output("rise_isr", rd, 32'h1);
    gpio_i = 32'h0;
    idle(CDC + 1);
    rd_reg(32'h18, rd, er);
    check_output("fall_isr", rd, 32'h3);
    wr_reg(32'h18, 4'hF, 32'h3);
    check_output("w1c_irq", {31'b0, irq0}, 32'h0);
    rd_reg(32'h18, rd, er);
    check_output("w1c_isr", rd, 32'h0);

    $display("[TB] W1C colliding with a new edge");
    gpio_i = 32'h1;
    idle(CDC + 1);
    gpio_i = 32'h0;
    idle(CDC + 1);
    gpio_i = 32'h1;
    idle(CDC);
    wr_reg(32'h18, 4'hF, 32'h1);
    check_output("collide_irq", {31'b0, irq0}, 32'h1);
    rd_reg(32'h18, rd, er);
    check_output("collide_isr", rd, 32'h1);

    $display("[TB] address errors and byte lanes");
    rd_reg(32'h1C, rd, er);
    check_output("err_1c", {31'b0, er}, 32'h1);
    check_output("err_1c_rdt", rd, 32'h0);
    rd_reg(32'h40, rd, er);
    check_output("err_40", {31'b0, er}, 32'h1);
    check_output("err_40_rdt", rd, 32'h0);
    wr_reg(32'h28, 4'hF, 32'hFFFFFFFF);
    wr_reg(32'h04, 4'h2, 32'h0000AA00);
    rd_reg(32'h04, rd, er);
    check_output("lane1_out", rd, 32'h8123AA60);

    $display("[TB] reset during a transfer");
    rst = 1'b1;
    wr_reg(32'h04, 4'hF, 32'hFFFFFFFF);
    rst = 1'b0;
    rd_reg(32'h04, rd, er);
    check_output("rst_mid_out", rd, 32'h0);
    check_output("rst_mid_irq", {31'b0, irq0}, 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) gpio_i = $urandom;
      else if ($urandom_range(0, 2) == 0) gpio_i = gpio_i ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) a = 32'h28 + 32'($urandom_range(0, 6) * 4);
      else a = 32'($urandom_range(0, 9) * 4);
      rst = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0:       idle(1);
        1:       rd_reg(a, rd, er);
        default: apply_stimulus(1'b1, 1'b1, a, 4'($urandom_range(0, 15)), $urandom, rd, er);
      endcase
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
